// File: rtl/glb_read_streamer.sv
// GLB read-side master: walks a strided address sequence, absorbs the 1-cycle
// GLB read latency through a 2-entry FIFO and presents a valid/ready stream.
module glb_read_streamer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_stride,
  output logic [3:0]        glb_w_en,
  output logic [ADDR_W-1:0] glb_address,
  input  logic [DATA_W-1:0] glb_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, r_stride, r_last_addr;
  logic [LEN_W-1:0]  r_remain;
  logic              r_inflight, r_inflight_last, r_done;
  logic [DATA_W-1:0] r_fifo_data [2];
  logic [1:0]        r_fifo_last;
  logic              r_wr_ptr, r_rd_ptr;
  logic [1:0]        r_count;

  logic w_accept, w_pop, w_issue, w_final_pop, w_last_issue;

  assign out_valid    = (r_count != 2'd0);
  assign out_data     = r_fifo_data[r_rd_ptr];
  assign out_last     = out_valid & r_fifo_last[r_rd_ptr];
  assign w_pop        = out_valid & out_ready;
  assign w_final_pop  = w_pop & out_last;
  assign w_accept     = cmd_valid & cmd_ready;
  // Counting this cycle's pop lets issue resume the same cycle the consumer frees a slot.
  assign w_issue      = (r_state == S_ISSUE) &&
                        (((r_count - {1'b0, w_pop}) + {1'b0, r_inflight}) < 2'd2);
  assign w_last_issue = w_issue && (r_remain == LEN_W'(1));
  assign glb_address  = w_issue ? r_addr : r_last_addr;
  assign glb_w_en     = 4'b0000;
  assign done         = r_done;

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid && (cmd_len != '0)) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_final_pop)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_stride        <= '0;
      r_last_addr     <= '0;
      r_remain        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
      r_fifo_data[0]  <= '0;
      r_fifo_data[1]  <= '0;
      r_fifo_last     <= '0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_accept && (cmd_len == '0)) || ((r_state == S_DRAIN) && w_final_pop);
      if (w_accept) begin
        r_addr   <= cmd_addr;
        r_stride <= cmd_stride;
        r_remain <= cmd_len;
      end else if (w_issue) begin
        r_addr      <= r_addr + r_stride;
        r_remain    <= r_remain - LEN_W'(1);
        r_last_addr <= r_addr;
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;
      if (r_inflight) begin
        r_fifo_data[r_wr_ptr] <= glb_read_data;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule
